// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/MEM pipeline stages, the shared single-port RAM and
// the memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              i_if_kill;
    logic              i_mem_read;
    logic              i_mem_write;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_wdata;

    logic              o_ram_req;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic              i_ram_ready;
    logic [DATA_W-1:0] i_ram_rdata;

    logic              o_if_valid;
    logic [DATA_W-1:0] o_if_rdata;
    logic              o_mem_valid;
    logic [DATA_W-1:0] o_mem_rdata;

    logic              o_pc_keep;
    logic              o_IF_ID_keep;
    logic              o_ID_EX_keep;
    logic              o_EX_MEM_keep;
    logic              o_IF_ID_flush;
    logic              o_MEM_WB_flush;

    // Arbiter side.
    modport master (
        input  i_if_req, i_if_addr, i_if_kill,
        input  i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
        input  i_ram_ready, i_ram_rdata,
        output o_ram_req, o_ram_we, o_ram_addr, o_ram_wdata,
        output o_if_valid, o_if_rdata, o_mem_valid, o_mem_rdata,
        output o_pc_keep, o_IF_ID_keep, o_ID_EX_keep, o_EX_MEM_keep,
        output o_IF_ID_flush, o_MEM_WB_flush
    );

    // Pipeline / RAM side.
    modport slave (
        output i_if_req, i_if_addr, i_if_kill,
        output i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
        output i_ram_ready, i_ram_rdata,
        input  o_ram_req, o_ram_we, o_ram_addr, o_ram_wdata,
        input  o_if_valid, o_if_rdata, o_mem_valid, o_mem_rdata,
        input  o_pc_keep, o_IF_ID_keep, o_ID_EX_keep, o_EX_MEM_keep,
        input  o_IF_ID_flush, o_MEM_WB_flush
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and MEM-stage accesses onto one single-port RAM,
// favouring MEM but bounding how long a waiting fetch can be starved.
module mem_port_arbiter #(
    parameter int unsigned MAX_MEM_STREAK = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned StreakW = $clog2(MAX_MEM_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_MEM_STREAK);

    typedef enum logic [1:0] {StIdle, StIfBusy, StMemBusy, StResp} state_e;

    state_e              state_q, state_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic                drop_q, drop_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                if_valid_q, if_valid_d;
    logic                mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

    logic mem_req;
    logic if_want;
    logic mem_stall;
    logic if_stall;

    assign mem_req = bus.i_mem_read | bus.i_mem_write;
    // A fetch being redirected this cycle is not worth granting.
    assign if_want = bus.i_if_req & ~bus.i_if_kill;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        drop_d      = drop_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (mem_req && ((streak_q < StreakMax) || !if_want)) begin
                    state_d     = StMemBusy;
                    ram_addr_d  = bus.i_mem_addr;
                    ram_wdata_d = bus.i_mem_wdata;
                    ram_we_d    = bus.i_mem_write;
                    streak_d    = if_want ? streak_q + 1'b1 : '0;
                end else if (if_want) begin
                    state_d    = StIfBusy;
                    ram_addr_d = bus.i_if_addr;
                    ram_we_d   = 1'b0;
                    streak_d   = '0;
                end
            end
            StIfBusy: begin
                if (bus.i_if_kill) begin
                    drop_d = 1'b1;
                end
                if (bus.i_ram_ready) begin
                    state_d    = StResp;
                    if_rdata_d = bus.i_ram_rdata;
                    if_valid_d = ~(drop_q | bus.i_if_kill);
                end
            end
            StMemBusy: begin
                if (bus.i_ram_ready) begin
                    state_d     = StResp;
                    mem_rdata_d = bus.i_ram_rdata;
                    mem_valid_d = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
                drop_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            streak_q    <= '0;
            drop_q      <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.o_ram_req   = (state_q == StIfBusy) || (state_q == StMemBusy);
    assign bus.o_ram_we    = ram_we_q;
    assign bus.o_ram_addr  = ram_addr_q;
    assign bus.o_ram_wdata = ram_wdata_q;
    assign bus.o_if_valid  = if_valid_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_mem_valid = mem_valid_q;
    assign bus.o_mem_rdata = mem_rdata_q;

    // A MEM stall freezes the whole front of the pipe; a lone fetch stall only
    // holds the PC and feeds bubbles into decode.
    assign mem_stall = mem_req & ~mem_valid_q;
    assign if_stall  = bus.i_if_req & ~if_valid_q & ~bus.i_if_kill;

    assign bus.o_pc_keep      = mem_stall | if_stall;
    assign bus.o_IF_ID_keep   = mem_stall;
    assign bus.o_ID_EX_keep   = mem_stall;
    assign bus.o_EX_MEM_keep  = mem_stall;
    assign bus.o_MEM_WB_flush = mem_stall;
    assign bus.o_IF_ID_flush  = if_stall & ~mem_stall;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter against a schedule-based model:
// each grant predicts its request window, completion cycle and returned data.
module tb_mem_port_arbiter;
    localparam int unsigned MaxStreak = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .MAX_MEM_STREAK(MaxStreak),
        .ADDR_W        (32),
        .DATA_W        (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    bit          acc_on, acc_mem, acc_we, acc_drop;
    logic [31:0] acc_addr, acc_wdata;
    int          g_cyc, rdy_cyc;
    int          streak;
    int          force_wait = -1;
    logic [31:0] exp_if_rdata, exp_mem_rdata;
    bit          last_if_v, last_mem_v;
    logic [31:0] ram [logic [31:0]];

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return (a * 32'h9e37_79b9) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_mis++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, want);
        end
    endtask

    task automatic model_clear();
        acc_on        = 1'b0;
        acc_drop      = 1'b0;
        streak        = 0;
        exp_if_rdata  = '0;
        exp_mem_rdata = '0;
        last_if_v     = 1'b0;
        last_mem_v    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ram_req"}, 32'(bus.o_ram_req), 0);
        chk({tag, "_ram_we"}, 32'(bus.o_ram_we), 0);
        chk({tag, "_ram_addr"}, bus.o_ram_addr, 0);
        chk({tag, "_ram_wdata"}, bus.o_ram_wdata, 0);
        chk({tag, "_if_valid"}, 32'(bus.o_if_valid), 0);
        chk({tag, "_mem_valid"}, 32'(bus.o_mem_valid), 0);
        chk({tag, "_if_rdata"}, bus.o_if_rdata, 0);
        chk({tag, "_mem_rdata"}, bus.o_mem_rdata, 0);
    endtask

    // One cycle: drive RAM response, check outputs, advance the model, move to next negedge.
    task automatic tick();
        bit          req_e, ifv_e, memv_e, m_stall, i_stall, mreq, want;
        logic [31:0] rd;
        int          w;
        req_e = acc_on && (cyc > g_cyc) && (cyc <= rdy_cyc);
        bus.i_ram_ready = req_e && (cyc == rdy_cyc);
        rd = bus.i_ram_ready ? ram_rd(acc_addr) : 32'($urandom);
        bus.i_ram_rdata = rd;
        ifv_e  = acc_on && !acc_mem && (cyc == rdy_cyc + 1) && !acc_drop;
        memv_e = acc_on && acc_mem && (cyc == rdy_cyc + 1);
        #1;
        chk("ram_req", 32'(bus.o_ram_req), 32'(req_e));
        if (req_e) begin
            chk("ram_addr", bus.o_ram_addr, acc_addr);
            chk("ram_we", 32'(bus.o_ram_we), 32'(acc_we));
            if (acc_we) chk("ram_wdata", bus.o_ram_wdata, acc_wdata);
        end
        chk("if_valid", 32'(bus.o_if_valid), 32'(ifv_e));
        chk("mem_valid", 32'(bus.o_mem_valid), 32'(memv_e));
        chk("if_rdata", bus.o_if_rdata, exp_if_rdata);
        chk("mem_rdata", bus.o_mem_rdata, exp_mem_rdata);
        m_stall = (bus.i_mem_read | bus.i_mem_write) && !memv_e;
        i_stall = bus.i_if_req && !ifv_e && !bus.i_if_kill;
        chk("stall_ctl",
            32'({bus.o_pc_keep, bus.o_IF_ID_keep, bus.o_ID_EX_keep, bus.o_EX_MEM_keep,
                 bus.o_MEM_WB_flush, bus.o_IF_ID_flush}),
            32'({m_stall | i_stall, m_stall, m_stall, m_stall, m_stall, i_stall & ~m_stall}));

        if (acc_on) begin
            if (!acc_mem && (cyc > g_cyc) && (cyc <= rdy_cyc) && bus.i_if_kill) acc_drop = 1'b1;
            if (cyc == rdy_cyc) begin
                if (acc_mem) begin
                    exp_mem_rdata = rd;
                    if (acc_we) ram[acc_addr] = acc_wdata;
                end else begin
                    exp_if_rdata = rd;
                end
            end
            if (cyc == rdy_cyc + 1) acc_on = 1'b0;
        end else begin
            mreq = bus.i_mem_read | bus.i_mem_write;
            want = bus.i_if_req & ~bus.i_if_kill;
            w = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
            if (mreq && ((streak < MaxStreak) || !want)) begin
                acc_on = 1'b1; acc_mem = 1'b1; acc_we = bus.i_mem_write; acc_drop = 1'b0;
                acc_addr = bus.i_mem_addr; acc_wdata = bus.i_mem_wdata;
                g_cyc = cyc; rdy_cyc = cyc + 1 + w;
                streak = want ? streak + 1 : 0;
            end else if (want) begin
                acc_on = 1'b1; acc_mem = 1'b0; acc_we = 1'b0; acc_drop = 1'b0;
                acc_addr = bus.i_if_addr;
                g_cyc = cyc; rdy_cyc = cyc + 1 + w;
                streak = 0;
            end
        end
        last_if_v  = ifv_e;
        last_mem_v = memv_e;
        @(negedge clk);
        cyc++;
    endtask

    task automatic mid_reset();
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        model_clear();
        bus.i_ram_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc += 2;
    endtask

    initial begin
        logic [31:0] pc;
        logic [1:0]  m_op;
        bus.i_if_req = 1'b0; bus.i_if_addr = '0; bus.i_if_kill = 1'b0;
        bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0;
        bus.i_mem_addr = '0; bus.i_mem_wdata = '0;
        bus.i_ram_ready = 1'b0; bus.i_ram_rdata = '0;
        model_clear();
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b1;

        // Fetch only, zero-wait RAM.
        ram[32'h0040_0000] = 32'h2408_0005;
        force_wait = 0;
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0040_0000;
        repeat (3) tick();
        chk("d1_if_rdata", bus.o_if_rdata, 32'h2408_0005);
        bus.i_if_req = 1'b0;
        tick();

        // Fetch and load together: load first, then fetch.
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0040_0004;
        bus.i_mem_read = 1'b1; bus.i_mem_addr = 32'h1000_0004;
        repeat (3) tick();
        chk("d2_mem_first", bus.o_mem_rdata, ram_rd(32'h1000_0004));
        bus.i_mem_read = 1'b0;
        repeat (3) tick();
        chk("d2_if_second", bus.o_if_rdata, ram_rd(32'h0040_0004));

        // MEM requests back-to-back with fetch waiting: fifth grant goes to fetch.
        bus.i_if_addr = 32'h0040_0008;
        bus.i_mem_read = 1'b1; bus.i_mem_addr = 32'h1000_000C;
        repeat (13) tick();
        chk("d3_fifth_addr", bus.o_ram_addr, 32'h0040_0008);
        chk("d3_fifth_we", 32'(bus.o_ram_we), 0);
        repeat (2) tick();
        bus.i_if_req = 1'b0; bus.i_mem_read = 1'b0;
        tick();

        // Kill during a 3-wait fetch drops it; the refetch uses the new PC.
        force_wait = 3;
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0040_0100;
        tick();
        bus.i_if_kill = 1'b1; bus.i_if_addr = 32'h0040_0200;
        tick();
        bus.i_if_kill = 1'b0;
        repeat (3) tick();
        chk("d4_dropped", 32'(bus.o_if_valid), 0);
        repeat (2) tick();
        chk("d4_new_addr", bus.o_ram_addr, 32'h0040_0200);
        bus.i_if_req = 1'b0;
        repeat (5) tick();
        // Kill in idle suppresses that cycle's fetch grant.
        bus.i_if_req = 1'b1; bus.i_if_kill = 1'b1;
        tick();
        bus.i_if_req = 1'b0; bus.i_if_kill = 1'b0;
        tick();

        // Store with five wait cycles.
        force_wait = 5;
        bus.i_mem_write = 1'b1; bus.i_mem_addr = 32'h1000_0008; bus.i_mem_wdata = 32'hDEAD_BEEF;
        repeat (7) tick();
        chk("d5_mem_valid", 32'(bus.o_mem_valid), 1);
        bus.i_mem_write = 1'b0;
        tick();

        // Reset in the middle of a load abandons it.
        force_wait = 3;
        bus.i_mem_read = 1'b1; bus.i_mem_addr = 32'h1000_0008;
        repeat (2) tick();
        bus.i_mem_read = 1'b0;
        mid_reset();
        repeat (6) tick();

        // Random pipeline traffic.
        force_wait = -1;
        pc = 32'h0040_0000;
        m_op = 2'd0;
        for (int i = 0; i < 1500; i++) begin
            if (last_if_v) pc = pc + 32'd4;
            bus.i_if_kill = ($urandom_range(0, 11) == 0);
            if (bus.i_if_kill) pc = 32'h0040_0000 + 32'($urandom_range(0, 255) << 2);
            bus.i_if_req  = ($urandom_range(0, 7) != 0);
            bus.i_if_addr = pc;
            if (last_mem_v || (m_op == 2'd0 && $urandom_range(0, 2) == 0)) begin
                m_op = 2'($urandom_range(0, 3));
                bus.i_mem_addr  = 32'h1000_0000 + 32'($urandom_range(0, 7) << 2);
                bus.i_mem_wdata = 32'($urandom);
            end
            bus.i_mem_read  = m_op[0];
            bus.i_mem_write = m_op[1];
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_MEM_STREAK, default 4: consecutive MEM-port grants allowed while an IF request waits.
REQ-002 SHALL have parameter ADDR_W, default 32: memory address width.
REQ-003 SHALL have parameter DATA_W, default 32: memory data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 i_if_req  input  1  fetch stage requests an instruction read.
REQ-007 i_if_addr  input  ADDR_W  fetch address (PC).
REQ-008 i_if_kill  input  1  branch/jump redirect; the in-flight fetch is stale.
REQ-009 i_mem_read / i_mem_write  input  1 each  MEM-stage load/store request.
REQ-010 i_mem_addr, i_mem_wdata  input  ADDR_W, DATA_W  MEM-stage address and store data.
REQ-011 o_ram_req, o_ram_we  output  1 each  request and write-enable to the shared single-port RAM.
REQ-012 o_ram_addr, o_ram_wdata  output  ADDR_W, DATA_W  registered RAM address and write data.
REQ-013 i_ram_ready, i_ram_rdata  input  1, DATA_W  RAM completion strobe and read data.
REQ-014 o_if_valid, o_if_rdata  output  1, DATA_W  one-cycle fetch completion and instruction.
REQ-015 o_mem_valid, o_mem_rdata  output  1, DATA_W  one-cycle load/store completion and load data.
REQ-016 o_pc_keep, o_IF_ID_keep, o_ID_EX_keep, o_EX_MEM_keep  output  1 each  stage hold controls.
REQ-017 o_IF_ID_flush, o_MEM_WB_flush  output  1 each  bubble insertion controls.

Function
REQ-018 FSM states SHALL be IDLE, IF_BUSY, MEM_BUSY, RESP.
REQ-019 In IDLE with MEM request pending (read or write) and streak < MAX_MEM_STREAK or no IF request: go MEM_BUSY, latch mem address/data/we, streak++ if i_if_req else streak=0.
REQ-020 In IDLE with i_if_req and (no MEM request or streak == MAX_MEM_STREAK): go IF_BUSY, latch i_if_addr, we=0, streak=0.
REQ-021 o_ram_req SHALL be 1 exactly in IF_BUSY/MEM_BUSY; first request cycle is the cycle after the grant decision.
REQ-022 In *_BUSY with i_ram_ready: capture i_ram_rdata into the matching o_*_rdata, go RESP; without i_ram_ready: hold all RAM outputs stable.
REQ-023 In RESP: assert the matching o_*_valid for exactly one cycle, issue no grant, then go IDLE (minimum 3 cycles request-to-valid with zero-wait RAM).
REQ-024 i_if_kill in IF_BUSY SHALL set a drop flag; on i_ram_ready the access completes but o_if_valid stays 0 in RESP; drop flag cleared on entering IDLE.
REQ-025 i_if_kill in IDLE SHALL suppress that cycle's IF grant; i_if_kill has no effect on MEM transactions.
REQ-026 mem_stall = (i_mem_read | i_mem_write) & ~o_mem_valid; if_stall = i_if_req & ~o_if_valid & ~i_if_kill.
REQ-027 mem_stall: o_pc_keep, o_IF_ID_keep, o_ID_EX_keep, o_EX_MEM_keep = 1, o_MEM_WB_flush = 1, o_IF_ID_flush = 0.
REQ-028 if_stall alone: o_pc_keep = 1, o_IF_ID_flush = 1, all other stage controls 0.
REQ-029 Neither stall: all stage controls 0; stall outputs SHALL be combinational from inputs and registered valids.
REQ-030 o_*_rdata SHALL hold last captured value until next capture of the same port.
REQ-031 Simultaneous i_mem_read and i_mem_write SHALL be treated as write.

Reset
REQ-032 reset low SHALL immediately force IDLE, streak=0, drop=0, o_ram_req=0, o_ram_we=0, o_if_valid=0, o_mem_valid=0, o_*_rdata=0, o_ram_addr/wdata=0, independent of clk.
REQ-033 reset asserted mid-transaction SHALL abandon it; no valid issued after release; first grant no earlier than first clk edge with reset high.

Verification
REQ-034 IF only, addr 0x0040_0000, ready on 1st req cycle, rdata 0x2408_0005 -> o_if_valid 1 cycle, o_if_rdata 0x2408_0005, o_pc_keep=1/o_IF_ID_flush=1 until valid.
REQ-035 IF + MEM read together, MEM addr 0x1000_0004 -> MEM served first, all four keeps=1 and o_MEM_WB_flush=1 until o_mem_valid, then IF served.
REQ-036 MEM requests every IDLE with IF pending, MAX_MEM_STREAK=4 -> 5th grant is IF; streak resets to 0.
REQ-037 i_if_kill in IF_BUSY, ready after 3 wait cycles -> no o_if_valid; next grant uses new i_if_addr.
REQ-038 Store 0xDEAD_BEEF to 0x1000_0008 with i_ram_ready delayed 5 cycles -> o_ram_we=1, addr/wdata stable 6 cycles, o_mem_valid 1 cycle after ready.
REQ-039 reset low in MEM_BUSY -> o_ram_req=0 same cycle, no o_mem_valid after release, FSM IDLE.
